// File: rtl/glitch_monitor_ctrl.sv
// Session controller for a bank of glitch monitors: calibration reset window,
// armed glitch accounting and round-robin reporting over one valid/ready port.
module glitch_monitor_ctrl #(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 8,
  parameter int CAL_CYCLES = 4
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    start_i,
  input  logic                    stop_i,
  input  logic [N_CH-1:0]         glitch_i,
  output logic                    mon_rstn_o,
  output logic                    armed_o,
  output logic                    busy_o,
  output logic                    rpt_valid_o,
  input  logic                    rpt_ready_i,
  output logic [$clog2(N_CH)-1:0] rpt_chan_o,
  output logic [CNT_W-1:0]        rpt_count_o,
  output logic [1:0]              dbg_state_o
);

  localparam int CH_W  = $clog2(N_CH);
  localparam int CAL_W = $clog2(CAL_CYCLES + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_CAL, ST_ARMED, ST_DRAIN} state_e;

  // Report port: rpt_valid_o holds with stable chan/count until rpt_valid_o && rpt_ready_i
  // on a rising clk_i edge; valid then drops for at least one cycle before the next report.

  state_e            state_q, state_d;
  logic [CAL_W-1:0]  cal_cnt_q;
  logic              mon_rstn_q;
  logic [CNT_W-1:0]  count_q [N_CH];
  logic [N_CH-1:0]   pending_q;
  logic [CH_W-1:0]   rr_ptr_q;
  logic              rpt_valid_q;
  logic [CH_W-1:0]   rpt_chan_q;
  logic [CNT_W-1:0]  rpt_count_q;

  logic              session_start;
  logic              count_en;
  logic              sel_found;
  logic [CH_W-1:0]   sel_idx;
  logic              sel_fire;
  logic [N_CH-1:0]   sel_mask;
  logic              handshake;

  assign session_start = (state_q == ST_IDLE) && start_i;
  assign count_en      = (state_q == ST_ARMED);
  assign handshake     = rpt_valid_q && rpt_ready_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_CAL;
      ST_CAL:   if (cal_cnt_q == '0) state_d = ST_ARMED;
      ST_ARMED: if (stop_i) state_d = ST_DRAIN;
      ST_DRAIN: if ((pending_q == '0) && !rpt_valid_q) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o      = (state_q != ST_IDLE);
    armed_o     = (state_q == ST_ARMED);
    dbg_state_o = state_q;
    mon_rstn_o  = mon_rstn_q;
    rpt_valid_o = rpt_valid_q;
    rpt_chan_o  = rpt_chan_q;
    rpt_count_o = rpt_count_q;
  end

  // Calibration window: counter loaded with CAL_CYCLES-1 gives exactly CAL_CYCLES low cycles.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cal_cnt_q  <= '0;
      mon_rstn_q <= 1'b1;
    end else if (session_start) begin
      cal_cnt_q  <= CAL_W'(CAL_CYCLES - 1);
      mon_rstn_q <= 1'b0;
    end else if (state_q == ST_CAL) begin
      if (cal_cnt_q == '0) mon_rstn_q <= 1'b1;
      else                 cal_cnt_q  <= cal_cnt_q - 1'b1;
    end
  end

  // Round-robin pick: first pending channel at or after the pointer, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (!sel_found && pending_q[(int'(rr_ptr_q) + i) % N_CH]) begin
        sel_found = 1'b1;
        sel_idx   = CH_W'((int'(rr_ptr_q) + i) % N_CH);
      end
    end
  end

  assign sel_fire = ((state_q == ST_ARMED) || (state_q == ST_DRAIN)) && !rpt_valid_q && sel_found;
  assign sel_mask = sel_fire ? (N_CH'(1) << sel_idx) : '0;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int k = 0; k < N_CH; k++) count_q[k] <= '0;
      pending_q <= '0;
    end else if (session_start) begin
      for (int k = 0; k < N_CH; k++) count_q[k] <= '0;
      pending_q <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (count_en && glitch_i[k] && (count_q[k] != '1)) count_q[k] <= count_q[k] + 1'b1;
      end
      // A glitch in the selection cycle re-arms the bit it clears.
      pending_q <= (pending_q & ~sel_mask) | (count_en ? glitch_i : '0);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rpt_valid_q <= 1'b0;
      rpt_chan_q  <= '0;
      rpt_count_q <= '0;
      rr_ptr_q    <= '0;
    end else if (sel_fire) begin
      rpt_valid_q <= 1'b1;
      rpt_chan_q  <= sel_idx;
      rpt_count_q <= count_q[sel_idx];
    end else if (handshake) begin
      rpt_valid_q <= 1'b0;
      rr_ptr_q    <= (rpt_chan_q == CH_W'(N_CH - 1)) ? '0 : rpt_chan_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_glitch_monitor_ctrl.sv
// Directed bench for glitch_monitor_ctrl: calibration window, round-robin
// reporting, held reports, saturation, drain sequencing and asynchronous reset.
module tb_glitch_monitor_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic       stop;
  logic [3:0] glitch;
  logic       ready;
  logic       mon_rstn;
  logic       armed;
  logic       busy;
  logic       rpt_valid;
  logic [1:0] rpt_chan;
  logic [7:0] rpt_count;
  logic [1:0] dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  glitch_monitor_ctrl #(.N_CH(4), .CNT_W(8), .CAL_CYCLES(4)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .start_i     (start),
    .stop_i      (stop),
    .glitch_i    (glitch),
    .mon_rstn_o  (mon_rstn),
    .armed_o     (armed),
    .busy_o      (busy),
    .rpt_valid_o (rpt_valid),
    .rpt_ready_i (ready),
    .rpt_chan_o  (rpt_chan),
    .rpt_count_o (rpt_count),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mon_rstn"}, 32'(mon_rstn), 1);
    check({tag, "_armed"},    32'(armed), 0);
    check({tag, "_busy"},     32'(busy), 0);
    check({tag, "_valid"},    32'(rpt_valid), 0);
    check({tag, "_chan"},     32'(rpt_chan), 0);
    check({tag, "_count"},    32'(rpt_count), 0);
  endtask

  // Start a session and walk the calibration window, glitching throughout it.
  task automatic run_start(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 1);
    check({tag, "_mon0"}, 32'(mon_rstn), 0);
    glitch = 4'b1111;
    for (int i = 1; i < 4; i++) begin
      tick();
      check({tag, "_mon_low"}, 32'(mon_rstn), 0);
      check({tag, "_armed_low"}, 32'(armed), 0);
    end
    glitch = 4'b0000;
    tick();
    check({tag, "_mon_high"}, 32'(mon_rstn), 1);
    check({tag, "_armed_high"}, 32'(armed), 1);
    check({tag, "_busy_armed"}, 32'(busy), 1);
    check({tag, "_no_rpt"}, 32'(rpt_valid), 0);
  endtask

  int          hs_chan[$];
  int          hs_cnt[$];
  logic [31:0] last_sat;
  int          fall;
  int          last_hs;
  int          exp_chan[3] = '{0, 1, 2};
  int          exp_cnt[3]  = '{2, 4, 2};

  initial begin
    rstn   = 1'b0;
    start  = 1'b0;
    stop   = 1'b0;
    glitch = 4'b0000;
    ready  = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    rstn = 1'b1;
    for (int i = 0; i < 8; i++) tick();

    // Calibration, glitches during CAL must leave nothing pending.
    run_start("cal1");
    tick();
    tick();
    check("cal_glitch_ignored", 32'(rpt_valid), 0);

    // Two channels in one cycle, ready held high.
    ready  = 1'b1;
    glitch = 4'b0101;
    tick();
    glitch = 4'b0000;
    check("rr_pre_valid", 32'(rpt_valid), 0);
    tick();
    check("rr_a_valid", 32'(rpt_valid), 1);
    check("rr_a_chan", 32'(rpt_chan), 0);
    check("rr_a_count", 32'(rpt_count), 1);
    tick();
    check("rr_gap_valid", 32'(rpt_valid), 0);
    tick();
    check("rr_b_valid", 32'(rpt_valid), 1);
    check("rr_b_chan", 32'(rpt_chan), 2);
    check("rr_b_count", 32'(rpt_count), 1);
    tick();
    check("rr_done_valid", 32'(rpt_valid), 0);
    tick();
    check("rr_idle_valid", 32'(rpt_valid), 0);

    // Held report on channel 1 while more glitches arrive.
    ready  = 1'b0;
    glitch = 4'b0010;
    tick();
    glitch = 4'b0000;
    tick();
    check("hold_chan", 32'(rpt_chan), 1);
    check("hold_count", 32'(rpt_count), 1);
    glitch = 4'b0010;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("hold_valid_stable", 32'(rpt_valid), 1);
      check("hold_chan_stable", 32'(rpt_chan), 1);
      check("hold_count_stable", 32'(rpt_count), 1);
    end
    glitch = 4'b0000;
    ready  = 1'b1;
    tick();
    check("hold_hs_valid", 32'(rpt_valid), 0);
    tick();
    check("hold_next_valid", 32'(rpt_valid), 1);
    check("hold_next_chan", 32'(rpt_chan), 1);
    check("hold_next_count", 32'(rpt_count), 3);
    tick();
    check("hold_next_done", 32'(rpt_valid), 0);

    // Saturation: 300 glitches on channel 3.
    last_sat = 32'hffff;
    glitch   = 4'b1000;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (rpt_valid && rpt_chan == 2'd3) last_sat = 32'(rpt_count);
    end
    glitch = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rpt_valid && rpt_chan == 2'd3) last_sat = 32'(rpt_count);
    end
    check("sat_count", last_sat, 255);
    check("sat_quiet", 32'(rpt_valid), 0);

    // Stop (with start also high) in the same cycle as glitches on 0..2.
    ready  = 1'b0;
    glitch = 4'b0111;
    stop   = 1'b1;
    start  = 1'b1;
    tick();
    stop   = 1'b0;
    start  = 1'b0;
    glitch = 4'b1111;
    check("drain_armed", 32'(armed), 0);
    check("drain_busy", 32'(busy), 1);
    check("drain_valid0", 32'(rpt_valid), 0);
    fall    = -1;
    last_hs = -1;
    for (int i = 0; i < 20 && fall < 0; i++) begin
      ready = (i % 2 == 0);
      if (rpt_valid && ready) begin
        hs_chan.push_back(int'(rpt_chan));
        hs_cnt.push_back(int'(rpt_count));
        last_hs = i;
      end
      tick();
      if (!busy) fall = i;
    end
    glitch = 4'b0000;
    ready  = 1'b0;
    check("drain_n_reports", 32'(hs_chan.size()), 3);
    for (int k = 0; k < 3; k++) begin
      check("drain_chan", (k < hs_chan.size()) ? 32'(hs_chan[k]) : 32'hdead, 32'(exp_chan[k]));
      check("drain_count", (k < hs_cnt.size()) ? 32'(hs_cnt[k]) : 32'hdead, 32'(exp_cnt[k]));
    end
    check("drain_busy_fall", 32'(fall), 32'(last_hs + 1));
    check("drain_end_valid", 32'(rpt_valid), 0);

    // Start and stop together in IDLE, then reset mid-CAL.
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("both_idle_busy", 32'(busy), 1);
    check("both_idle_mon", 32'(mon_rstn), 0);
    tick();
    check("cal2_mon", 32'(mon_rstn), 0);
    rstn = 1'b0;
    #1;
    check_reset_outputs("rst_cal");
    tick();
    rstn = 1'b1;
    tick();
    run_start("cal3");

    // Reset with a report outstanding.
    ready  = 1'b0;
    glitch = 4'b0100;
    tick();
    glitch = 4'b0000;
    tick();
    check("out_valid", 32'(rpt_valid), 1);
    check("out_chan", 32'(rpt_chan), 2);
    check("out_count", 32'(rpt_count), 1);
    rstn = 1'b0;
    #1;
    check_reset_outputs("rst_rpt");
    tick();
    rstn = 1'b1;
    tick();
    tick();
    check("rst_rpt_dropped", 32'(rpt_valid), 0);
    check("rst_rpt_idle", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
